ram_wr_trace: RTL

- Hardware write tracker placed downstream of the cpu_garage data-memory write port.
- Snoops every RAM write (we, ram_address, cpu_out_m) and tags it with a free-running cycle timestamp.
- Buffers tagged writes in a FIFO and streams them out over a valid/ready interface to a UART/debug drain.
- Provides a synthesizable equivalent of the bench memory-access log, so write traces can be compared on silicon.

---
 rtl/ram_wr_trace_if.sv | 30 +++
 rtl/ram_wr_trace.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ram_wr_trace_if.sv
// Trace stream interface between the write tracker and its drain.
//   master : drives trace_valid and the head entry (trace_addr/data/ts), samples trace_ready
//   slave  : samples the head entry, drives trace_ready
interface ram_wr_trace_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int TS_W   = 32
);
  logic              trace_valid;
  logic              trace_ready;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [TS_W-1:0]   trace_ts;

  modport master (
    output trace_valid,
    output trace_addr,
    output trace_data,
    output trace_ts,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_addr,
    input  trace_data,
    input  trace_ts,
    output trace_ready
  );
endinterface

// File: rtl/ram_wr_trace.sv
// RAM write tracker. Snoops CPU data-memory writes inside an address window,
// tags each with a free-running cycle timestamp, queues it in a FIFO and
// presents the oldest entry first-word-fall-through on the trace stream.
//   Clk, Reset        : clock, async active-low reset
//   we, ram_address,
//   cpu_out_m         : snooped CPU write port
//   trc (master)      : trace stream (valid/ready + head addr/data/ts)
//   level             : FIFO occupancy
//   drop_cnt          : saturating count of writes lost to a full FIFO
//   overflow          : sticky drop flag
//   clr_ovf           : synchronous clear of overflow and drop_cnt
module ram_wr_trace #(
  parameter int                ADDR_W = 16,
  parameter int                DATA_W = 16,
  parameter int                TS_W   = 32,
  parameter int                DEPTH  = 16,
  parameter logic [ADDR_W-1:0] WIN_LO = '0,
  parameter logic [ADDR_W-1:0] WIN_HI = '1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        ram_address,
  input  logic [DATA_W-1:0]        cpu_out_m,
  ram_wr_trace_if.master           trc,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt,
  output logic                     overflow,
  input  logic                     clr_ovf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W + TS_W;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
  // Window test as a single offset compare so that default (full-range)
  // bounds do not degenerate into always-true comparisons.
  localparam logic [ADDR_W:0] SPAN = {1'b0, WIN_HI} - {1'b0, WIN_LO};

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [TS_W-1:0]   r_ts;
  logic [15:0]       r_drop_cnt;
  logic              r_ovf;
  logic              r_valid;
  logic [ENT_W-1:0]  r_head;

  logic [ADDR_W:0]   w_off;
  logic              w_cap;
  logic              w_pop;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic [ENT_W-1:0]  w_entry;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [LVL_W-1:0]  w_lvl_nxt;
  logic [ENT_W-1:0]  w_head_nxt;

  // An address below WIN_LO wraps into the top half of the extended range.
  assign w_off   = {1'b0, ram_address} - {1'b0, WIN_LO};
  assign w_cap   = we && (w_off <= SPAN);
  assign w_pop   = r_valid && trc.trace_ready;
  assign w_full  = (r_level == FULL);
  assign w_push  = w_cap && (!w_full || w_pop);
  assign w_drop  = w_cap && w_full && !w_pop;
  assign w_entry = {ram_address, cpu_out_m, r_ts};

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_pop) w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);

    w_lvl_nxt = r_level;
    if (w_push && !w_pop)      w_lvl_nxt = r_level + LVL_W'(1);
    else if (!w_push && w_pop) w_lvl_nxt = r_level - LVL_W'(1);

    // The next head is the entry being written this cycle when it lands in
    // the slot the read pointer is about to point at (empty, or last entry
    // popped); otherwise it is already in the array.
    w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = w_entry;
  end

  // Storage carries no reset; stale words are hidden behind level.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_ts       <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
      r_head     <= '0;
    end else begin
      r_ts     <= r_ts + TS_W'(1);
      r_level  <= w_lvl_nxt;
      r_valid  <= (w_lvl_nxt != '0);
      r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      // Head only moves on a push or pop so it holds under backpressure.
      if (w_push || w_pop) r_head <= w_head_nxt;

      if (clr_ovf) begin
        r_ovf      <= 1'b0;
        r_drop_cnt <= '0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign trc.trace_valid = r_valid;
  assign trc.trace_addr  = r_head[ENT_W-1 -: ADDR_W];
  assign trc.trace_data  = r_head[TS_W +: DATA_W];
  assign trc.trace_ts    = r_head[TS_W-1:0];
  assign level           = r_level;
  assign drop_cnt        = r_drop_cnt;
  assign overflow        = r_ovf;
endmodule
